// File: rtl/i2c_target_rx.sv
// Write-only I2C target: syncs SCL/SDA, matches ADDR+W, ACKs bytes and hands them over valid/ready.
// Pin events act 3 clk after they occur; a full buffer stretches SCL until freed or STRETCH_MAX expires.
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         STRETCH_MAX = 70000,
  parameter int         CBITS       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_drive_low,
  output logic       sda_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_DATA_ACK, S_STRETCH, S_IGNORE
  } state_t;

  localparam int               LIMIT_I = (STRETCH_MAX > 0) ? STRETCH_MAX - 1 : 0;
  localparam logic [CBITS-1:0] LIMIT   = CBITS'(LIMIT_I);

  state_t             state_q, state_d;
  logic               scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
  logic               sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [CBITS-1:0]   stretch_cnt_q, stretch_cnt_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               scl_drive_q, scl_drive_d;
  logic               sda_drive_q, sda_drive_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic scl_rise, scl_fall, start_det, stop_det, handshake, buf_free;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign handshake = rx_valid_q & rx_ready;
  assign buf_free  = ~rx_valid_q | handshake;

  always_comb begin
    scl_s1_d      = scl_in;
    scl_s2_d      = scl_s1_q;
    scl_prev_d    = scl_s2_q;
    sda_s1_d      = sda_in;
    sda_s2_d      = sda_s1_q;
    sda_prev_d    = sda_s2_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    stretch_cnt_d = stretch_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    scl_drive_d   = scl_drive_q;
    sda_drive_d   = sda_drive_q;
    busy_d        = busy_q;
    overrun_d     = 1'b0;

    if (handshake) rx_valid_d = 1'b0;

    if (start_det || stop_det) begin
      state_d       = start_det ? S_ADDR : S_IDLE;
      busy_d        = start_det;
      scl_drive_d   = 1'b0;
      sda_drive_d   = 1'b0;
      bit_cnt_d     = 4'd0;
      stretch_cnt_d = '0;
    end else begin
      // ACK states also count the 9th rising edge so its falling edge can be recognised
      if (scl_rise && (state_q inside {S_ADDR, S_RX, S_ADDR_ACK, S_DATA_ACK})) begin
        shift_d   = {shift_q[6:0], sda_s2_q};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        S_ADDR: if (scl_fall && bit_cnt_q == 4'd8) begin
          if (shift_q == {ADDR, 1'b0}) begin
            sda_drive_d = 1'b1;
            state_d     = S_ADDR_ACK;
          end else begin
            state_d     = S_IGNORE;
          end
        end
        S_RX: if (scl_fall && bit_cnt_q == 4'd8) begin
          if (buf_free) begin
            rx_data_d   = shift_q;
            rx_valid_d  = 1'b1;
            sda_drive_d = 1'b1;
            state_d     = S_DATA_ACK;
          end else begin
            scl_drive_d   = 1'b1;
            stretch_cnt_d = '0;
            state_d       = S_STRETCH;
          end
        end
        S_STRETCH: begin
          if (buf_free) begin
            // SCL stays held one more cycle so the ACK is set up before release
            rx_data_d   = shift_q;
            rx_valid_d  = 1'b1;
            sda_drive_d = 1'b1;
            state_d     = S_DATA_ACK;
          end else if ((STRETCH_MAX != 0) && (stretch_cnt_q == LIMIT)) begin
            overrun_d   = 1'b1;
            scl_drive_d = 1'b0;
            state_d     = S_IGNORE;
          end else if (stretch_cnt_q != {CBITS{1'b1}}) begin
            stretch_cnt_d = stretch_cnt_q + 1'b1;
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          scl_drive_d = 1'b0;
          if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_drive_d = 1'b0;
            bit_cnt_d   = 4'd0;
            state_d     = S_RX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      scl_s1_q      <= 1'b1;
      scl_s2_q      <= 1'b1;
      scl_prev_q    <= 1'b1;
      sda_s1_q      <= 1'b1;
      sda_s2_q      <= 1'b1;
      sda_prev_q    <= 1'b1;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      stretch_cnt_q <= '0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      scl_drive_q   <= 1'b0;
      sda_drive_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      scl_s1_q      <= scl_s1_d;
      scl_s2_q      <= scl_s2_d;
      scl_prev_q    <= scl_prev_d;
      sda_s1_q      <= sda_s1_d;
      sda_s2_q      <= sda_s2_d;
      sda_prev_q    <= sda_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      stretch_cnt_q <= stretch_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      scl_drive_q   <= scl_drive_d;
      sda_drive_q   <= sda_drive_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign scl_drive_low = scl_drive_q;
  assign sda_drive_low = sda_drive_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: open-drain bus with a stretch-aware master, byte scoreboard on the rx handshake.
// Directed cases cover ACK/NACK, stretch, timeout, aborted byte and reset; then randomized transactions.
module tb_i2c_target_rx;
  localparam int SMAX = 200;
  localparam int H    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl_low = 1'b0, m_sda_low = 1'b0;
  logic       scl_in, sda_in;
  logic       scl_drive_low, sda_drive_low, rx_valid, rx_ready, busy, overrun;
  logic [7:0] rx_data;
  logic       ready_dir = 1'b0, ready_rand = 1'b0, rand_en = 1'b0;

  assign scl_in   = !(m_scl_low || scl_drive_low);
  assign sda_in   = !(m_sda_low || sda_drive_low);
  assign rx_ready = rand_en ? ready_rand : ready_dir;

  i2c_target_rx #(.ADDR(7'h42), .STRETCH_MAX(SMAX), .CBITS(17)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         compared = 0, mismatched = 0;
  int         cyc = 0;
  int         valid_cycles = 0, ovr_cnt = 0, exp_ovr = 0;
  logic       scl_seen = 1'b0, sda_seen = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed byte must be the next one the model expects
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cycles++;
      if (scl_drive_low) scl_seen = 1'b1;
      if (sda_drive_low) sda_seen = 1'b1;
      if (overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
        end else begin
          chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 ready_rand = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (!scl_in && n < 3000) begin
      tick(1);
      n++;
    end
    if (!scl_in) chk("scl_release_timeout", int'(scl_in), 1);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; tick(H/2);
    m_scl_low = 1'b0; wait_scl_high(); tick(H/2);
    m_sda_low = 1'b1; tick(H/2);
    m_scl_low = 1'b1; tick(H/2);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; tick(H/2);
    m_scl_low = 1'b0; wait_scl_high(); tick(H/2);
    m_sda_low = 1'b0; tick(H);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = !b; tick(H/2);
    m_scl_low = 1'b0; wait_scl_high(); tick(H);
    m_scl_low = 1'b1; tick(H/2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda_low = 1'b0; tick(H/2);
    m_scl_low = 1'b0; wait_scl_high(); tick(H/2);
    ack = !sda_in; tick(H/2);
    m_scl_low = 1'b1; tick(H/2);
  endtask

  logic ack, ps, pc;
  int   n, t0, t1;

  initial begin
    tick(4);
    rst = 1'b0;
    chk("rst_scl_drive", int'(scl_drive_low), 0);
    chk("rst_sda_drive", int'(sda_drive_low), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    tick(10);

    // Simple write with a ready consumer
    ready_dir = 1'b1; valid_cycles = 0; scl_seen = 1'b0;
    i2c_start();
    chk("busy_after_start", int'(busy), 1);
    send_byte(8'h84, ack); chk("t1_addr_ack", int'(ack), 1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, ack); chk("t1_data_ack", int'(ack), 1);
    i2c_stop();
    chk("busy_after_stop", int'(busy), 0);
    chk("t1_valid_cycles", valid_cycles, 1);
    chk("t1_no_stretch", int'(scl_seen), 0);

    // Wrong address: nothing driven, nothing delivered
    valid_cycles = 0; sda_seen = 1'b0;
    i2c_start();
    send_byte(8'h86, ack); chk("t2_addr_nack", int'(ack), 0);
    send_byte(8'h11, ack); chk("t2_data_nack", int'(ack), 0);
    chk("t2_busy_ignore", int'(busy), 1);
    i2c_stop();
    chk("t2_no_sda_drive", int'(sda_seen), 0);
    chk("t2_no_valid", valid_cycles, 0);

    // Read bit NACKed, repeated START with write ACKed
    i2c_start();
    send_byte(8'h85, ack); chk("t3_read_nack", int'(ack), 0);
    i2c_start();
    send_byte(8'h84, ack); chk("t3_rs_ack", int'(ack), 1);
    i2c_stop();

    // Stretch released by the consumer
    ready_dir = 1'b0;
    i2c_start();
    send_byte(8'h84, ack); chk("t4_addr_ack", int'(ack), 1);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    send_byte(8'h3C, ack); chk("t4_b1_ack", int'(ack), 1);
    fork
      send_byte(8'hC3, ack);
      begin
        n = 0;
        while (!scl_drive_low && n < 3000) begin @(negedge clk); n++; end
        chk("t4_stretch_start", int'(scl_drive_low), 1);
        chk("t4_held_data", int'(rx_data), 8'h3C);
        chk("t4_held_valid", int'(rx_valid), 1);
        tick(100);
        ready_dir = 1'b1;
        ps = sda_drive_low; pc = scl_drive_low; n = 0;
        while (n < 50) begin
          @(negedge clk); n++;
          if (!scl_drive_low) break;
          ps = sda_drive_low; pc = scl_drive_low;
        end
        chk("t4_ack_before_release", int'({ps, pc, sda_drive_low, scl_drive_low}), 4'b1110);
      end
    join
    chk("t4_b2_ack", int'(ack), 1);
    i2c_stop();

    // Stretch timeout: overrun, NACK, held byte preserved
    ready_dir = 1'b0;
    i2c_start();
    send_byte(8'h84, ack);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, ack); chk("t5_b1_ack", int'(ack), 1);
    exp_ovr++;
    fork
      send_byte(8'h5A, ack);
      begin
        n = 0;
        while (!scl_drive_low && n < 3000) begin @(negedge clk); n++; end
        t0 = cyc; n = 0;
        while (!overrun && n < 3000) begin @(negedge clk); n++; end
        t1 = cyc;
        chk("t5_timeout_cycles", t1 - t0, SMAX);
        chk("t5_scl_released", int'(scl_drive_low), 0);
        chk("t5_data_kept", int'(rx_data), 8'h3C);
      end
    join
    chk("t5_b2_nack", int'(ack), 0);
    i2c_stop();
    ready_dir = 1'b1;
    tick(5);

    // STOP in the middle of a byte
    valid_cycles = 0;
    i2c_start();
    send_byte(8'h84, ack);
    for (int i = 0; i < 4; i++) send_bit(1'(i < 2));
    i2c_stop();
    chk("t6_busy", int'(busy), 0);
    chk("t6_drives", int'({scl_drive_low, sda_drive_low}), 0);
    chk("t6_no_valid", valid_cycles, 0);
    i2c_start();
    send_byte(8'h84, ack); chk("t6_addr_ack", int'(ack), 1);
    exp_q.push_back(8'h77);
    send_byte(8'h77, ack); chk("t6_data_ack", int'(ack), 1);
    i2c_stop();

    // Reset during a stretch
    ready_dir = 1'b0;
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h99, ack);
    fork
      send_byte(8'h66, ack);
      begin
        n = 0;
        while (!scl_drive_low && n < 3000) begin @(negedge clk); n++; end
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("t7_rst_drives", int'({scl_drive_low, sda_drive_low}), 0);
        chk("t7_rst_valid", int'(rx_valid), 0);
        chk("t7_rst_busy", int'(busy), 0);
        rst = 1'b0;
      end
    join
    chk("t7_nack_after_rst", int'(ack), 0);
    i2c_stop();

    // Randomized transactions against the protocol model
    rand_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      logic [7:0] a, d;
      logic       a_ok;
      int         nb;
      case ($urandom_range(0, 3))
        0:       a = 8'h84;
        1:       a = 8'h85;
        2:       a = 8'h86;
        default: a = 8'($urandom);
      endcase
      a_ok = (a == 8'h84);
      nb = $urandom_range(1, 3);
      i2c_start();
      send_byte(a, ack); chk("rnd_addr_ack", int'(ack), int'(a_ok));
      for (int k = 0; k < nb; k++) begin
        d = 8'($urandom);
        if (a_ok) exp_q.push_back(d);
        send_byte(d, ack); chk("rnd_data_ack", int'(ack), int'(a_ok));
      end
      if ($urandom_range(0, 1) == 1) i2c_stop();
    end
    i2c_stop();

    rand_en = 1'b0; ready_dir = 1'b1;
    tick(50);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("overrun_count", ovr_cnt, exp_ovr);
    chk("final_busy", int'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
